// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array feeder blocks.
//   feed_state_e : feeder FSM encoding (IDLE, STREAM, DRAIN)
//   DEF_N        : default lane count (array rows fed)
//   DEF_WIDTH    : default bits per lane operand
//   lane_lsb()   : LSB position of a lane inside a packed N*WIDTH vector
package systolic_pkg;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} feed_state_e;

  localparam int unsigned DEF_N     = 4;
  localparam int unsigned DEF_WIDTH = 32;

  function automatic int unsigned lane_lsb(input int unsigned lane,
                                           input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift chain carrying {valid, last, data} for one feeder lane.
// Output is the last stage, so a word entering at an edge appears DEPTH edges
// later. Synchronous active-high reset zero-fills every stage.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/last/data  word entering stage 0
//   out_valid/last/data word leaving stage DEPTH-1 (registered)
module skew_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic             out_last,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH+1:0] stage [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (rst) stage[k] <= '0;
        else     stage[k] <= {in_valid, in_last, in_data};
      end
    end else begin : g_tail
      always_ff @(posedge clk) begin
        if (rst) stage[k] <= '0;
        else     stage[k] <= stage[k-1];
      end
    end
  end

  assign {out_valid, out_last, out_data} = stage[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Operand feeder for the systolic array edge: accepts one N-lane vector per
// cycle and emits it skewed, lane i delayed by i+1 cycles. Idle cycles insert
// zero bubbles. After the last vector the feeder blocks input for N cycles
// while the skew drains, pulsing done as the last operand leaves lane N-1.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   in_valid   in_data/in_last valid this cycle
//   in_ready   feeder accepts a vector this cycle (decoded from state)
//   in_data    N lanes, lane i = in_data[i*WIDTH +: WIDTH]
//   in_last    final vector of the current stream
//   out_data   skewed operands, packed like in_data
//   out_valid  per-lane operand valid
//   out_last   per-lane last marker
//   done       one-cycle pulse when the last operand leaves lane N-1
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic               in_last,
  output logic [N*WIDTH-1:0] out_data,
  output logic [N-1:0]       out_valid,
  output logic [N-1:0]       out_last,
  output logic               done
);

  localparam int unsigned CNT_W = $clog2(N + 1);

  feed_state_e      state;
  logic [CNT_W-1:0] drain_cnt;
  logic             accept;

  assign in_ready = (state != DRAIN);
  assign accept   = in_valid & in_ready;

  // Non-accepted cycles push an all-zero word, so out_data is 0 whenever
  // out_valid is 0.
  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_delay_line #(
      .DEPTH (i + 1),
      .WIDTH (WIDTH)
    ) u_line (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (accept),
      .in_last   (accept & in_last),
      .in_data   (accept ? in_data[lane_lsb(i, WIDTH) +: WIDTH] : '0),
      .out_valid (out_valid[i]),
      .out_last  (out_last[i]),
      .out_data  (out_data[lane_lsb(i, WIDTH) +: WIDTH])
    );
  end

  // done is registered one edge early so it is high in the cycle where
  // drain_cnt==1, coinciding with out_last[N-1].
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, STREAM: begin
          if (accept) begin
            if (in_last) begin
              state     <= DRAIN;
              drain_cnt <= CNT_W'(N);
              done      <= (N == 1);
            end else begin
              state <= STREAM;
            end
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt - CNT_W'(1);
          done      <= (N > 1) && (drain_cnt == CNT_W'(2));
          if (drain_cnt == CNT_W'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
module tb_systolic_skew_feeder;

  localparam int N = 4;
  localparam int W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N*W-1:0]   in_data;
  logic             in_last;
  logic [N*W-1:0]   out_data;
  logic [N-1:0]     out_valid;
  logic [N-1:0]     out_last;
  logic             done;

  systolic_skew_feeder #(.N(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .done      (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Scoreboard: per-lane queue of expected {valid,last,data}; lane i is
  // prefilled with i+1 zero words so its front lags the input by i+1 cycles.
  logic [W+1:0] lane_q [N][$];
  int cyc;       // current cycle index since reset release
  int last_edge; // edge at which the last vector was accepted

  function automatic logic exp_ready(input int c);
    return !(c > last_edge && c <= last_edge + N);
  endfunction

  task automatic reinit();
    for (int i = 0; i < N; i++) begin
      lane_q[i].delete();
      for (int k = 0; k <= i; k++) lane_q[i].push_back('0);
    end
    cyc       = 0;
    last_edge = -100;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d obs=%b exp=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [W+1:0] obs, exp;
    for (int i = 0; i < N; i++) begin
      obs = {out_valid[i], out_last[i], out_data[i*W +: W]};
      if (lane_q[i].size() == 0) exp = 'x;
      else exp = lane_q[i].pop_front();
      total++;
      assert (obs === exp) else begin
        bad++;
        $error("FAIL lane%0d cyc=%0d obs=%h exp=%h", i, cyc, obs, exp);
      end
    end
    check_bit("in_ready", in_ready, exp_ready(cyc));
    check_bit("done", done, cyc == last_edge + N);
  endtask

  // Check this cycle, drive inputs, record expectations, advance one edge.
  task automatic step(input logic v, input logic l, input logic [N*W-1:0] d);
    logic acc;
    check_outputs();
    in_valid = v;
    in_last  = l;
    in_data  = d;
    acc = v && exp_ready(cyc);
    for (int i = 0; i < N; i++)
      lane_q[i].push_back(acc ? {1'b1, l, d[i*W +: W]} : '0);
    if (acc && l) last_edge = cyc;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    assert (out_valid === '0 && out_last === '0 && out_data === '0 && done === 1'b0)
    else begin
      bad++;
      $error("FAIL %s obs=%b/%b/%h/%b exp=0/0/0/0", tag, out_valid, out_last, out_data, done);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // T1: reset held 3 cycles with in_valid asserted
    rst = 1'b1; in_valid = 1'b1; in_last = 1'b0; in_data = '1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check_reset_outputs("reset_hold");
    end
    rst = 1'b0; in_valid = 1'b0;
    reinit();
    idle(2);

    // T2: single last vector, lanes 1,2,3,4
    step(1'b1, 1'b1, 32'h04030201);
    idle(6);

    // T3: back-to-back A,B,C (C last)
    step(1'b1, 1'b0, 32'h1A2A3A4A);
    step(1'b1, 1'b0, 32'h1B2B3B4B);
    step(1'b1, 1'b1, 32'h1C2C3C4C);
    idle(7);

    // T4: bubble between A and B(last)
    step(1'b1, 1'b0, 32'hA1A2A3A4);
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 32'hB1B2B3B4);
    idle(6);

    // in_last without in_valid is ignored
    step(1'b0, 1'b1, 32'h55555555);
    step(1'b0, 1'b1, 32'h66666666);
    idle(2);

    // T5: 0xFF held on in_valid through DRAIN, then a new stream
    step(1'b1, 1'b1, 32'h11223344);
    for (int k = 0; k < N; k++) step(1'b1, 1'b0, 32'hFFFFFFFF);
    step(1'b1, 1'b1, 32'h77665544);
    idle(6);

    // T6: reset in the second drain cycle
    step(1'b1, 1'b1, 32'h04030201);
    step(1'b0, 1'b0, '0);
    check_outputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("reset_mid_drain");
    check_bit("ready_after_rst", in_ready, 1'b1);
    reinit();
    idle(6);
    check_outputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
